mul_arbiter: RTL

- Shares one iterative multiply unit between R requesters (e.g. the integer pipeline M-extension port and a secondary issue port).
- Arbitrates valid/ready requests round-robin and drives the multiplier's enable, operation and operands.
- Waits out the multiplier's stall, then holds the result in a response buffer until the owning requester accepts it.
- Sits between the requesters and the multiplier; contains no arithmetic.

---
 rtl/mul_arbiter_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/mul_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mul_arbiter_pkg.sv
// Shared types for the multiplier arbiter and the units that talk to it.
package mul_arbiter_pkg;

   typedef enum logic [1:0] {
      mulop_mul,
      mulop_mulh,
      mulop_mulhsu,
      mulop_mulhu
   } rv32_mulop;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP,
      DRAIN
   } mul_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned R = 2,
   localparam int unsigned IdxW = (R > 1) ? $clog2(R) : 1
) (
   input  logic [R-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   output logic [R-1:0]    gnt,
   output logic [IdxW-1:0] idx,
   output logic            any
);

   logic [IdxW-1:0] k;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = '0;
      for (int unsigned i = 0; i < R; i++) begin
         k = IdxW'((32'(ptr) + i) % R);
         if (!any && req[k]) begin
            any = 1'b1;
            idx = k;
         end
      end
      gnt[idx] = any;
   end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one iterative multiplier between R requesters; holds each result until its owner
// accepts it. No arithmetic here.
module mul_arbiter
   import mul_arbiter_pkg::*;
#(
   parameter int unsigned N = 32,
   parameter int unsigned R = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic [R-1:0]    i_req_valid,
   output logic [R-1:0]    o_req_ready,
   input  rv32_mulop       i_req_op [R],
   input  logic [N-1:0]    i_req_a  [R],
   input  logic [N-1:0]    i_req_b  [R],
   input  logic [N-1:0]    i_req_c  [R],
   output logic [R-1:0]    o_rsp_valid,
   input  logic [R-1:0]    i_rsp_ready,
   output logic [N-1:0]    o_rsp_data,
   output logic            o_mul_en,
   output rv32_mulop       o_mul_op,
   output logic [N-1:0]    o_mul_a,
   output logic [N-1:0]    o_mul_b,
   output logic [N-1:0]    o_mul_c,
   input  logic [N-1:0]    i_mul_data,
   input  logic            i_mul_stall
);

   localparam int unsigned IdxW = (R > 1) ? $clog2(R) : 1;

   mul_arb_state_t  state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] owner_q;
   logic            entry_q;
   rv32_mulop       op_q;
   logic [N-1:0]    a_q, b_q, c_q, rsp_q;

   logic [R-1:0]    gnt;
   logic [IdxW-1:0] gnt_idx;
   logic            gnt_any;
   logic            hs;
   logic            capture;
   logic            mul_done;

   rr_arbiter #(
      .R (R)
   ) u_rr (
      .req (i_req_valid),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   // The stall seen on the entry cycle still reflects the multiplier's idle state.
   assign mul_done = !entry_q && !i_mul_stall;
   assign ptr_d    = (gnt_idx == IdxW'(R - 1)) ? '0 : gnt_idx + IdxW'(1);

   always_comb begin
      state_d     = state_q;
      o_req_ready = '0;
      o_rsp_valid = '0;
      o_mul_en    = 1'b0;
      hs          = 1'b0;
      capture     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!i_flush && gnt_any) begin
               o_req_ready = gnt;
               hs          = 1'b1;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            o_mul_en = 1'b1;
            if (i_flush) begin
               state_d = mul_done ? IDLE : DRAIN;
            end else if (mul_done) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            o_rsp_valid[owner_q] = 1'b1;
            if (i_flush || i_rsp_ready[owner_q]) state_d = IDLE;
         end
         DRAIN: begin
            o_mul_en = 1'b1;
            if (!i_mul_stall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         entry_q <= 1'b0;
         op_q    <= mulop_mul;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         entry_q <= hs;
         if (hs) begin
            ptr_q   <= ptr_d;
            owner_q <= gnt_idx;
            op_q    <= i_req_op[gnt_idx];
            a_q     <= i_req_a[gnt_idx];
            b_q     <= i_req_b[gnt_idx];
            c_q     <= i_req_c[gnt_idx];
         end
         if (capture) rsp_q <= i_mul_data;
      end
   end

   assign o_mul_op   = op_q;
   assign o_mul_a    = a_q;
   assign o_mul_b    = b_q;
   assign o_mul_c    = c_q;
   assign o_rsp_data = rsp_q;

   a_rsp_onehot: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_rsp_valid));

   a_mul_stable: assert property (@(posedge i_clk) disable iff (i_rst)
      o_mul_en |=> (!o_mul_en || $stable({o_mul_op, o_mul_a, o_mul_b, o_mul_c})));

endmodule
